// File: rtl/parity_check_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// parity check arbiter.
package parity_check_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RESP
    } state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CW    = 16;
    localparam int MAX_NREQ  = 8;

    // Scans downward so the last hit is the first asserted requester at or
    // above ptr; the wrap uses a compare so non-power-of-two NREQ works.
    function automatic int rrPick(input logic [MAX_NREQ-1:0] reqVec,
                                  input logic [2:0]          ptr,
                                  input int                  nreq);
        logic [3:0] idx;
        logic [2:0] pick;
        pick = '0;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= 4'(nreq)) begin
                    idx = idx - 4'(nreq);
                end
                if (reqVec[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return int'(pick);
    endfunction

endpackage

// File: rtl/parity_check_arbiter_checker.sv
// Shared even/odd checker resource: reports whether the operand value is even.
module odd_even_checker #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] number,
    output logic             is_even
);

    assign is_even = ((number % WIDTH'(2)) == '0);

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin sequencer sharing one odd_even_checker among NREQ requesters,
// returning tagged registered results and saturating even/odd tallies.
module parity_check_arbiter
    import parity_check_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = 2,
    parameter int CW    = DEF_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] num,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_is_even,
    output logic [CW-1:0]         even_cnt,
    output logic [CW-1:0]         odd_cnt
);

    state_t             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     id_q;
    logic [WIDTH-1:0]   operand_q;
    logic [NREQ-1:0]    gnt_q;
    logic               busy_q;
    logic               respValid_q;
    logic [IDW-1:0]     respId_q;
    logic               respIsEven_q;
    logic [CW-1:0]      evenCnt_q;
    logic [CW-1:0]      oddCnt_q;

    logic [IDW-1:0]     sel_d;
    logic [IDW-1:0]     ptr_d;
    logic               isEven;

    assign sel_d = IDW'(rrPick(MAX_NREQ'(req), 3'(ptr_q), NREQ));
    assign ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

    odd_even_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .number  (operand_q),
        .is_even (isEven)
    );

    // The operand is latched at grant time so later num changes cannot
    // disturb the in-flight result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            operand_q    <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            respValid_q  <= 1'b0;
            respId_q     <= '0;
            respIsEven_q <= 1'b0;
            evenCnt_q    <= '0;
            oddCnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        operand_q <= num[sel_d*WIDTH +: WIDTH];
                        id_q      <= sel_d;
                        gnt_q     <= NREQ'(1) << sel_d;
                        busy_q    <= 1'b1;
                        state_q   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    respIsEven_q <= isEven;
                    respId_q     <= id_q;
                    respValid_q  <= 1'b1;
                    gnt_q        <= '0;
                    ptr_q        <= ptr_d;
                    if (isEven) begin
                        if (evenCnt_q != '1) begin
                            evenCnt_q <= evenCnt_q + CW'(1);
                        end
                    end else begin
                        if (oddCnt_q != '1) begin
                            oddCnt_q <= oddCnt_q + CW'(1);
                        end
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    respValid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign busy         = busy_q;
    assign resp_valid   = respValid_q;
    assign resp_id      = respId_q;
    assign resp_is_even = respIsEven_q;
    assign even_cnt     = evenCnt_q;
    assign odd_cnt      = oddCnt_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Randomized self-checking bench for parity_check_arbiter, with a second
// narrow-counter instance to exercise tally saturation.
module tb_parity_check_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] num;

    logic [NREQ-1:0] gnt,  gntS;
    logic            busy, busyS;
    logic            respValid, respValidS;
    logic [IDW-1:0]  respId, respIdS;
    logic            respIsEven, respIsEvenS;
    logic [15:0]     evenCnt, oddCnt;
    logic [1:0]      evenCntS, oddCntS;

    int testsRun    = 0;
    int testsFailed = 0;
    int ptrModel    = 0;
    int evenTotal   = 0;
    int oddTotal    = 0;
    int lastId      = 0;
    int lastEven    = 0;

    always #5 clk = ~clk;

    parity_check_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .num(num), .gnt(gnt), .busy(busy),
        .resp_valid(respValid), .resp_id(respId), .resp_is_even(respIsEven),
        .even_cnt(evenCnt), .odd_cnt(oddCnt)
    );

    parity_check_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CW(2)) dutSat (
        .clk(clk), .reset(reset), .req(req), .num(num), .gnt(gntS), .busy(busyS),
        .resp_valid(respValidS), .resp_id(respIdS), .resp_is_even(respIsEvenS),
        .even_cnt(evenCntS), .odd_cnt(oddCntS)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int satCount(input int value, input int cw);
        int maxVal;
        maxVal = (1 << cw) - 1;
        return (value > maxVal) ? maxVal : value;
    endfunction

    task automatic checkCounters();
        checkOutput("even_cnt",      32'(evenCnt),  32'(satCount(evenTotal, 16)));
        checkOutput("odd_cnt",       32'(oddCnt),   32'(satCount(oddTotal, 16)));
        checkOutput("even_cnt_cw2",  32'(evenCntS), 32'(satCount(evenTotal, 2)));
        checkOutput("odd_cnt_cw2",   32'(oddCntS),  32'(satCount(oddTotal, 2)));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_gnt"},        32'(gnt),        32'(0));
        checkOutput({tag, "_busy"},       32'(busy),       32'(0));
        checkOutput({tag, "_resp_valid"}, 32'(respValid),  32'(0));
        checkOutput({tag, "_resp_id"},    32'(respId),     32'(lastId));
        checkOutput({tag, "_resp_even"},  32'(respIsEven), 32'(lastEven));
    endtask

    // One arbitration round: sample at t, grant at t+1, result at t+2, idle at t+3.
    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] n,
                                 input bit midReset);
        int winner;
        int idx;
        int reqInt;
        logic [WIDTH-1:0] opVal;
        req    = r;
        num    = n;
        reqInt = int'(r);
        winner = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptrModel + k) % NREQ;
            if (winner < 0 && ((reqInt >> idx) & 1) == 1) winner = idx;
        end
        opVal = (winner >= 0) ? WIDTH'(n >> (winner * WIDTH)) : '0;
        @(posedge clk); #1;
        if (winner < 0) begin
            checkIdleOutputs("noreq");
            return;
        end
        checkOutput("grant_onehot", 32'(gnt),       32'(1 << winner));
        checkOutput("grant_busy",   32'(busy),      32'(1));
        checkOutput("grant_rvalid", 32'(respValid), 32'(0));
        req = NREQ'($urandom);
        num = (NREQ*WIDTH)'($urandom);
        if (midReset) begin
            reset = 1'b0;
            @(posedge clk); #1;
            reset     = 1'b1;
            req       = '0;
            ptrModel  = 0;
            evenTotal = 0;
            oddTotal  = 0;
            lastId    = 0;
            lastEven  = 0;
            checkIdleOutputs("midreset");
            checkCounters();
            @(posedge clk); #1;
            checkIdleOutputs("dropped");
            return;
        end
        @(posedge clk); #1;
        if (opVal % 2 == 0) begin
            evenTotal++;
            lastEven = 1;
        end else begin
            oddTotal++;
            lastEven = 0;
        end
        lastId   = winner;
        ptrModel = (winner + 1) % NREQ;
        checkOutput("resp_valid",   32'(respValid),  32'(1));
        checkOutput("resp_id",      32'(respId),     32'(lastId));
        checkOutput("resp_is_even", 32'(respIsEven), 32'(lastEven));
        checkOutput("resp_gnt",     32'(gnt),        32'(0));
        checkOutput("resp_busy",    32'(busy),       32'(1));
        checkCounters();
        req = NREQ'($urandom);
        @(posedge clk); #1;
        checkIdleOutputs("after_resp");
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        num   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        checkCounters();
        reset = 1'b1;

        applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd6}, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, {8'd2, 8'd7, 8'd4, 8'd11}, 1'b0);
        applyStimulus(4'b0010, {8'd1, 8'd1, 8'd3, 8'd1}, 1'b0);
        applyStimulus(4'b1001, {8'd5, 8'd8, 8'd8, 8'd12}, 1'b0);
        applyStimulus(4'b1001, {8'd5, 8'd8, 8'd8, 8'd12}, 1'b0);
        applyStimulus(4'b0100, {8'd0, 8'd9, 8'd0, 8'd0}, 1'b0);
        applyStimulus(4'b0100, {8'd0, 8'd9, 8'd0, 8'd0}, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b0);
        applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0);

        for (int i = 0; i < 200; i++) begin
            applyStimulus(NREQ'($urandom), (NREQ*WIDTH)'($urandom),
                          ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
